// File: rtl/fp_mult_pipe.sv
// Purpose: pipelined multiplier for small {sign, exp, mant} float formats (no Inf/NaN), RNE or truncate, saturating.
// Latency: pair accepted at edge N -> out_valid after edge N+3; one product per cycle while out_ready is high.
// Backpressure: global stall; every stage holds while out_valid && !out_ready, in_ready = advance (combinational).
// Ports: clk/rst (sync, active-high); in_valid/in_ready + a/b operands; out_valid/out_ready + p product
//        and flags {overflow, underflow, inexact}, both held stable while stalled.
module fp_mult_pipe #(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3,
    parameter int BIAS  = 2**(EXP_W-1)-1,
    parameter int ROUND = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] p,
    output logic [2:0]           flags
);
    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int EW     = EXP_W + 3;
    localparam int EXT_W  = PROD_W + MAN_W + 2;
    localparam int TOP    = EXP_W + MAN_W;

    typedef logic signed [EW-1:0] sexp_t;

    localparam sexp_t E_ONE  = sexp_t'(1);
    localparam sexp_t E_ZERO = sexp_t'(0);
    localparam sexp_t E_MIN  = sexp_t'(1 - BIAS);
    localparam sexp_t E_BIAS = sexp_t'(BIAS);
    localparam sexp_t E_MAX  = sexp_t'(2**EXP_W - 1);
    localparam sexp_t SH_MAX = sexp_t'(MAN_W + 2);

    typedef struct packed {
        logic              zero;
        sexp_t             e;
        logic [SIG_W-1:0]  sig;
    } opnd_t;

    typedef struct packed {
        logic              sign;
        logic              zero;
        sexp_t             ea;
        sexp_t             eb;
        logic [SIG_W-1:0]  sa;
        logic [SIG_W-1:0]  sb;
    } s1_t;

    typedef struct packed {
        logic              sign;
        logic              zero;
        sexp_t             e;
        logic [PROD_W-1:0] prod;
    } s2_t;

    // Unbiased exponent plus a significand with the leading 1 at the top.
    // Subnormals are shifted up by the leading-zero count of {0, mant}.
    function automatic opnd_t decode(input logic [TOP-1:0] x);
        opnd_t            r;
        logic [EXP_W-1:0] ef;
        logic [SIG_W-1:0] s0;
        int               lz;
        ef     = x[TOP-1 -: EXP_W];
        s0     = {1'b0, x[MAN_W-1:0]};
        r.zero = (ef == '0) && (x[MAN_W-1:0] == '0);
        if (ef != '0) begin
            r.sig = {1'b1, x[MAN_W-1:0]};
            r.e   = sexp_t'(int'(ef) - BIAS);
        end else begin
            lz = SIG_W;
            for (int i = 0; i < SIG_W; i++) begin
                if (s0[i]) lz = SIG_W - 1 - i;
            end
            r.sig = s0 << lz;
            r.e   = sexp_t'(1 - BIAS - lz);
        end
        return r;
    endfunction

    logic              advance;
    logic              s0_vld, s1_vld, s2_vld;
    logic [TOP:0]      s0_a, s0_b;
    s1_t               s1, s1_nxt;
    s2_t               s2, s2_nxt;
    opnd_t             da, db;

    logic [PROD_W-1:0] norm;
    sexp_t             e_n, deficit, exp_b, exp_r;
    logic [EXT_W-1:0]  ext, shifted;
    logic [MAN_W-1:0]  mant, mant_r;
    logic              far, guard, sticky, inc, carry, sat, inexact;
    logic [TOP:0]      p_nxt;
    logic [2:0]        flags_nxt;

    assign advance  = out_ready || !out_valid;
    assign in_ready = advance;

    // S1: decode captured operands.
    always_comb begin
        da          = decode(s0_a[TOP-1:0]);
        db          = decode(s0_b[TOP-1:0]);
        s1_nxt.sign = s0_a[TOP] ^ s0_b[TOP];
        s1_nxt.zero = da.zero | db.zero;
        s1_nxt.ea   = da.e;
        s1_nxt.eb   = db.e;
        s1_nxt.sa   = da.sig;
        s1_nxt.sb   = db.sig;
    end

    // S2: exact significand product and exponent sum.
    always_comb begin
        s2_nxt.sign = s1.sign;
        s2_nxt.zero = s1.zero;
        s2_nxt.e    = s1.ea + s1.eb;
        s2_nxt.prod = PROD_W'(s1.sa) * PROD_W'(s1.sb);
    end

    // S3: normalise, denormalise on underflow, round, saturate.
    always_comb begin
        norm = s2.prod << 1;
        e_n  = s2.e;
        if (s2.prod[PROD_W-1]) begin
            norm = s2.prod;
            e_n  = s2.e + E_ONE;
        end
        deficit = E_MIN - e_n;
        ext     = {norm, {(MAN_W+2){1'b0}}};
        far     = deficit > SH_MAX;
        shifted = ext;
        if (far) begin
            shifted = '0;
        end else if (deficit > E_ZERO) begin
            shifted = ext >> deficit;
        end
        mant   = shifted[EXT_W-2 -: MAN_W];
        guard  = shifted[EXT_W-2-MAN_W];
        sticky = far | (|shifted[EXT_W-3-MAN_W:0]);
        // Integer bit survives only when no underflow shift happened.
        exp_b  = shifted[EXT_W-1] ? e_n + E_BIAS : E_ZERO;
        inc    = (ROUND != 0) && guard && (sticky || mant[0]);
        {carry, mant_r} = {1'b0, mant} + {{MAN_W{1'b0}}, inc};
        // Carry out of the mantissa bumps the exponent (subnormal -> min normal too).
        exp_r   = carry ? exp_b + E_ONE : exp_b;
        sat     = exp_r > E_MAX;
        inexact = guard | sticky | sat;
        p_nxt     = {s2.sign, exp_r[EXP_W-1:0], mant_r};
        flags_nxt = {sat, (exp_r == E_ZERO) && inexact, inexact};
        if (sat) begin
            p_nxt = {s2.sign, {TOP{1'b1}}};
        end
        if (s2.zero) begin
            p_nxt     = {s2.sign, {TOP{1'b0}}};
            flags_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_vld    <= 1'b0;
            s1_vld    <= 1'b0;
            s2_vld    <= 1'b0;
            out_valid <= 1'b0;
            p         <= '0;
            flags     <= '0;
        end else if (advance) begin
            s0_vld    <= in_valid;
            s1_vld    <= s0_vld;
            s2_vld    <= s1_vld;
            out_valid <= s2_vld;
            if (in_valid) begin
                s0_a <= a;
                s0_b <= b;
            end
            s1 <= s1_nxt;
            s2 <= s2_nxt;
            if (s2_vld) begin
                p     <= p_nxt;
                flags <= flags_nxt;
            end
        end
    end

endmodule
